seq_par_runner: RTL and testbench

- Parametrised multi-channel step sequencer, the generalised successor to the fixed 4-output, 8-bit sequential/parallel test top.
- On a start pulse it loads every channel register with INIT_VAL, then applies increment steps for a programmable number of iterations.
- Steps run either in parallel (all enabled channels per cycle) or sequentially (one channel per cycle, round-robin).
- Sits under the generated top as the reusable seq/par state-register engine; a done pulse and busy flag go to the controlling logic.

---
 rtl/seq_par_runner.sv | 163 ++++++++++++++++
 tb/tb_seq_par_runner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_par_runner.sv
// Multi-channel seq/par step engine: LOAD INIT_VAL, then loop_cnt iterations of +inc per channel.
// Optional SEQ_PAR_SAT_EN: saturating adds plus a per-channel sat_flag output.

module seq_par_lane #(
  parameter int WIDTH    = 8,
  parameter int INIT_VAL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_inc,
`ifdef SEQ_PAR_SAT_EN
  output logic             o_sat,
`endif
  output logic [WIDTH-1:0] o_val
);
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_sum;

`ifdef SEQ_PAR_SAT_EN
  logic [WIDTH:0] w_sum_ext;
  logic           r_sat;

  assign w_sum_ext = {1'b0, r_val} + {1'b0, i_inc};
  assign w_sum     = w_sum_ext[WIDTH] ? '1 : w_sum_ext[WIDTH-1:0];

  // Sticky until the next job's LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_sat <= 1'b0;
    else if (i_load)                   r_sat <= 1'b0;
    else if (i_step && w_sum_ext[WIDTH]) r_sat <= 1'b1;
  end

  assign o_sat = r_sat;
`else
  assign w_sum = r_val + i_inc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_val <= '0;
    else if (i_load) r_val <= WIDTH'(INIT_VAL);
    else if (i_step) r_val <= w_sum;
  end

  assign o_val = r_val;
endmodule

module seq_par_runner #(
  parameter int WIDTH    = 8,
  parameter int CH       = 4,
  parameter int INIT_VAL = 16,
  parameter int LOOPW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      inc,
  input  logic [CH-1:0]         ch_en,
  input  logic [LOOPW-1:0]      loop_cnt,
  output logic [CH*WIDTH-1:0]   ch_val,
  output logic                  busy,
  output logic                  done,
`ifdef SEQ_PAR_SAT_EN
  output logic [CH-1:0]         sat_flag,
`endif
  output logic [15:0]           run_cycles
);
  localparam int PTRW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic                        r_mode;
  logic [WIDTH-1:0]            r_inc;
  logic [CH-1:0]               r_ch_en;
  logic [LOOPW-1:0]            r_loop;
  logic [LOOPW-1:0]            r_iter;
  logic [PTRW-1:0]             r_ptr;
  logic [15:0]                 r_run_cycles;

  logic                        w_iter_end;
  logic                        w_last;
  logic                        w_load;
  logic [CH-1:0]               w_step;
  logic [CH-1:0][WIDTH-1:0]    w_vals;

  // An iteration ends every cycle in parallel mode, or when ptr wraps in sequential mode.
  assign w_iter_end = r_mode || (r_ptr == PTRW'(CH-1));
  assign w_last     = w_iter_end && (LOOPW'(r_iter + 1'b1) == r_loop);
  assign w_load     = (r_state == S_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = (r_loop == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode       <= 1'b0;
      r_inc        <= '0;
      r_ch_en      <= '0;
      r_loop       <= '0;
      r_iter       <= '0;
      r_ptr        <= '0;
      r_run_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode  <= mode;
          r_inc   <= inc;
          r_ch_en <= ch_en;
          r_loop  <= loop_cnt;
        end
        S_LOAD: begin
          r_iter       <= '0;
          r_ptr        <= '0;
          r_run_cycles <= '0;
        end
        S_RUN: begin
          if (r_run_cycles != 16'hFFFF) r_run_cycles <= r_run_cycles + 16'd1;
          if (!r_mode) r_ptr <= (r_ptr == PTRW'(CH-1)) ? '0 : r_ptr + 1'b1;
          if (w_iter_end) r_iter <= r_iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    assign w_step[gi] = (r_state == S_RUN) && r_ch_en[gi] &&
                        (r_mode || (r_ptr == PTRW'(gi)));

    seq_par_lane #(.WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_step (w_step[gi]),
      .i_inc  (r_inc),
`ifdef SEQ_PAR_SAT_EN
      .o_sat  (sat_flag[gi]),
`endif
      .o_val  (w_vals[gi])
    );
  end

  assign ch_val     = w_vals;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign run_cycles = r_run_cycles;
endmodule

// File: tb/tb_seq_par_runner.sv
// Directed bench for seq_par_runner at default parameters (WIDTH=8, CH=4, INIT_VAL=16).
module tb_seq_par_runner;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  inc = '0;
  logic [3:0]  ch_en = '0;
  logic [7:0]  loop_cnt = '0;
  logic [31:0] ch_val;
  logic        busy, done;
  logic [15:0] run_cycles;
`ifdef SEQ_PAR_SAT_EN
  logic [3:0]  sat_flag;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  int done_cnt;

  seq_par_runner dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inc(inc),
    .ch_en(ch_en), .loop_cnt(loop_cnt), .ch_val(ch_val), .busy(busy),
    .done(done),
`ifdef SEQ_PAR_SAT_EN
    .sat_flag(sat_flag),
`endif
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses start, optionally disturbs inputs mid-RUN, returns edges from start edge to done.
  task automatic run_job(input logic m, input logic [7:0] i, input logic [3:0] en,
                         input logic [7:0] lc, input bit disturb, output int l);
    @(negedge clk);
    mode = m; inc = i; ch_en = en; loop_cnt = lc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    while (l < 2000) begin
      @(negedge clk);
      if (disturb && l == 3) begin
        start = 1'b1; inc = 8'h55; ch_en = 4'b0000; loop_cnt = 8'd3; mode = ~m;
      end
      if (disturb && l == 4) start = 1'b0;
      if (done) break;
      @(posedge clk);
      l++;
    end
    if (l >= 2000) chk("done_timeout", 32'(l), 32'd0);
    // start held during DONE must be ignored
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_ch_val", ch_val, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_job(1'b1, 8'd1, 4'b0011, 8'd1, 1'b0, lat);
    chk("par_lat", 32'(lat), 32'd2);
    chk("par_val", ch_val, 32'h1010_1111);
    chk("par_cycles", {16'd0, run_cycles}, 32'd1);

    run_job(1'b0, 8'd1, 4'b1111, 8'd2, 1'b0, lat);
    chk("seq_lat", 32'(lat), 32'd9);
    chk("seq_val", ch_val, 32'h1212_1212);
    chk("seq_cycles", {16'd0, run_cycles}, 32'd8);

    run_job(1'b1, 8'hF0, 4'b0001, 8'd1, 1'b0, lat);
    chk("wrap_lat", 32'(lat), 32'd2);
`ifdef SEQ_PAR_SAT_EN
    chk("sat_val", ch_val, 32'h1010_10FF);
    chk("sat_flag", {28'd0, sat_flag}, 32'h1);
`else
    chk("wrap_val", ch_val, 32'h1010_1000);
`endif

    run_job(1'b1, 8'd7, 4'b1111, 8'd0, 1'b0, lat);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_val", ch_val, 32'h1010_1010);
    chk("zero_cycles", {16'd0, run_cycles}, 32'd0);

    run_job(1'b0, 8'd1, 4'b0000, 8'd1, 1'b0, lat);
    chk("noen_lat", 32'(lat), 32'd5);
    chk("noen_val", ch_val, 32'h1010_1010);

    run_job(1'b0, 8'd1, 4'b1111, 8'd2, 1'b1, lat);
    chk("dist_lat", 32'(lat), 32'd9);
    chk("dist_val", ch_val, 32'h1212_1212);
    chk("dist_cycles", {16'd0, run_cycles}, 32'd8);

    // Asynchronous reset between edges during RUN
    @(negedge clk);
    mode = 1'b0; inc = 8'd1; ch_en = 4'b1111; loop_cnt = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ch_val", ch_val, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;

    run_job(1'b1, 8'd1, 4'b0011, 8'd1, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_val", ch_val, 32'h1010_1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
